// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with request FSM and tagged output queue
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   PC, PCPlus4               current fetch address and its successor from the PC block
//   pc_advance                PC block may load its next value this cycle
//   flush                     redirect: empty queue, forget any in-flight response
//   imem_req/addr/gnt         instruction memory request channel
//   imem_rvalid/rdata         instruction memory response channel
//   id_valid/ready            decode handshake for the queue head
//   id_instr/pc/pcplus4       queue head contents
//   fetch_err                 misaligned PC, fetch suppressed
module fetch_unit #(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH       = 2,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] PCPlus4,
  output logic             pc_advance,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pcplus4,
  output logic             fetch_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] tag_pc_q, tag_pc_d;
  logic [WIDTH-1:0] tag_pc4_q, tag_pc4_d;

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [WIDTH-1:0] epc_q   [DEPTH];
  logic [WIDTH-1:0] epc_d   [DEPTH];
  logic [WIDTH-1:0] epc4_q  [DEPTH];
  logic [WIDTH-1:0] epc4_d  [DEPTH];

  logic push;
  logic pop;
  logic not_full;
  logic aligned;

  assign imem_addr = PC;
  assign not_full  = (count_q != DEPTH_C);
  assign aligned   = (PC[1:0] == 2'b00);

  // Request FSM: one outstanding request at most; a flush while waiting
  // parks in DROP so the late response is swallowed.
  always_comb begin
    state_d    = state_q;
    tag_pc_d   = tag_pc_q;
    tag_pc4_d  = tag_pc4_q;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    fetch_err  = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_err = !rst && not_full && !aligned;
        imem_req  = !rst && !flush && not_full && aligned;
        if (imem_req && imem_gnt) begin
          pc_advance = 1'b1;
          tag_pc_d   = PC;
          tag_pc4_d  = PCPlus4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output queue; flush wins over push and pop.
  always_comb begin
    id_valid = !rst && (count_q != '0);
    pop      = id_valid && id_ready && !flush;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    epc_d    = epc_q;
    epc4_d   = epc4_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = imem_rdata;
        epc_d[wr_ptr_q]   = tag_pc_q;
        epc4_d[wr_ptr_q]  = tag_pc4_q;
        wr_ptr_d          = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Head fields come from storage only, never straight from imem_rdata.
  always_comb begin
    id_instr   = RESET_INSTR;
    id_pc      = '0;
    id_pcplus4 = '0;
    if (id_valid) begin
      id_instr   = instr_q[rd_ptr_q];
      id_pc      = epc_q[rd_ptr_q];
      id_pcplus4 = epc4_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tag_pc_q  <= '0;
      tag_pc4_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      tag_pc_q  <= tag_pc_d;
      tag_pc4_q <= tag_pc4_d;
    end
  end

  // Entry storage needs no reset: it is only visible while id_valid.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    epc_q   <= epc_d;
    epc4_q  <= epc4_d;
  end

endmodule
